// File: rtl/ext_data_bus_if.sv
// External 8-bit data bus interface: sequences single-byte read/write cycles
// with strobe timing, WAIT stretching and timeout abort.
module ext_data_bus_if #(
  parameter int unsigned MAX_WAIT = 15,
  parameter logic [7:0]  OPEN_BUS = 8'hFF
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       RD,
  input  logic       WR,
  input  logic [7:0] DL_in,
  output logic [7:0] DL_out,
  output logic       DL_drive,
  input  logic [7:0] D_in,
  output logic [7:0] D_out,
  output logic       D_oe,
  output logic       nRD,
  output logic       nWR,
  input  logic       WAIT,
  output logic       BUSY,
  output logic       DONE,
  output logic       TIMEOUT,
  output logic [7:0] LATCH
);

  localparam int unsigned WCW = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RSTB = 3'd1,
    S_RDRV = 3'd2,
    S_WSET = 3'd3,
    S_WSTB = 3'd4,
    S_WHLD = 3'd5
  } state_e;

  state_e         state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [7:0]     latch_q, latch_d;
  logic [7:0]     wr_buf_q, wr_buf_d;
  logic           to_flag_q, to_flag_d;

  logic dl_drive_q, dl_drive_d;
  logic d_oe_q, d_oe_d;
  logic nrd_q, nrd_d;
  logic nwr_q, nwr_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic timeout_q, timeout_d;

  // Next-state, datapath loads, and output decode of the upcoming state
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    latch_d    = latch_q;
    wr_buf_d   = wr_buf_q;
    to_flag_d  = to_flag_q;

    case (state_q)
      S_IDLE: begin
        to_flag_d = 1'b0;
        if (WR) begin
          wr_buf_d = DL_in;
          state_d  = S_WSET;
        end else if (RD) begin
          wait_cnt_d = '0;
          state_d    = S_RSTB;
        end
      end
      S_RSTB: begin
        if (!WAIT) begin
          latch_d = D_in;
          state_d = S_RDRV;
        end else if (wait_cnt_q == WCW'(MAX_WAIT)) begin
          latch_d   = OPEN_BUS;
          to_flag_d = 1'b1;
          state_d   = S_RDRV;
        end else begin
          wait_cnt_d = WCW'(wait_cnt_q + 1'b1);
        end
      end
      S_RDRV: begin
        to_flag_d = 1'b0;
        state_d   = S_IDLE;
      end
      S_WSET: begin
        wait_cnt_d = '0;
        state_d    = S_WSTB;
      end
      S_WSTB: begin
        if (!WAIT) begin
          state_d = S_WHLD;
        end else if (wait_cnt_q == WCW'(MAX_WAIT)) begin
          to_flag_d = 1'b1;
          state_d   = S_WHLD;
        end else begin
          wait_cnt_d = WCW'(wait_cnt_q + 1'b1);
        end
      end
      S_WHLD: begin
        to_flag_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: begin
        to_flag_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase

    // Outputs registered from the next state so they align with state_q
    dl_drive_d = (state_d == S_RDRV);
    d_oe_d     = (state_d == S_WSET) || (state_d == S_WSTB) || (state_d == S_WHLD);
    nrd_d      = (state_d != S_RSTB);
    nwr_d      = (state_d != S_WSTB);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_RDRV) || (state_d == S_WHLD);
    timeout_d  = done_d && to_flag_d;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      latch_q    <= 8'h00;
      wr_buf_q   <= 8'h00;
      to_flag_q  <= 1'b0;
      dl_drive_q <= 1'b0;
      d_oe_q     <= 1'b0;
      nrd_q      <= 1'b1;
      nwr_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      latch_q    <= latch_d;
      wr_buf_q   <= wr_buf_d;
      to_flag_q  <= to_flag_d;
      dl_drive_q <= dl_drive_d;
      d_oe_q     <= d_oe_d;
      nrd_q      <= nrd_d;
      nwr_q      <= nwr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
    end
  end

  assign DL_out   = latch_q;
  assign LATCH    = latch_q;
  assign D_out    = wr_buf_q;
  assign DL_drive = dl_drive_q;
  assign D_oe     = d_oe_q;
  assign nRD      = nrd_q;
  assign nWR      = nwr_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign TIMEOUT  = timeout_q;

endmodule

// File: tb/tb_ext_data_bus_if.sv
// Bench for ext_data_bus_if: directed vector table, hand-written reset/hold
// sequences and random transactions checked cycle by cycle against a timeline model.
module tb_ext_data_bus_if;

  localparam int unsigned MAXW = 15;

  logic       CLK = 1'b0;
  logic       RESET, RD, WR, WAIT;
  logic [7:0] DL_in, D_in;
  logic [7:0] DL_out, D_out, LATCH;
  logic       DL_drive, D_oe, nRD, nWR, BUSY, DONE, TIMEOUT;

  int n_chk  = 0;
  int n_fail = 0;

  // Transaction-level model state: last byte read and last byte written
  logic [7:0] m_latch = 8'h00;
  logic [7:0] m_wrbuf = 8'h00;

  ext_data_bus_if #(.MAX_WAIT(MAXW), .OPEN_BUS(8'hFF)) dut (
    .CLK(CLK), .RESET(RESET), .RD(RD), .WR(WR), .DL_in(DL_in),
    .DL_out(DL_out), .DL_drive(DL_drive), .D_in(D_in), .D_out(D_out),
    .D_oe(D_oe), .nRD(nRD), .nWR(nWR), .WAIT(WAIT), .BUSY(BUSY),
    .DONE(DONE), .TIMEOUT(TIMEOUT), .LATCH(LATCH)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit         rd;
    bit         wr;
    logic [7:0] dl;
    logic [7:0] din;
    int         waits;
    logic [7:0] exp_latch;
    logic [7:0] exp_dout;
    bit         exp_to;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [7:0] e_latch, input logic e_dldrv,
                     input logic [7:0] e_dout, input logic e_doe, input logic e_nrd,
                     input logic e_nwr, input logic e_busy, input logic e_done,
                     input logic e_to);
    logic [30:0] act, exp;
    act = {LATCH, DL_out, DL_drive, D_out, D_oe, nRD, nWR, BUSY, DONE, TIMEOUT};
    exp = {e_latch, e_latch, e_dldrv, e_dout, e_doe, e_nrd, e_nwr, e_busy, e_done, e_to};
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got {latch,dlout,dldrv,dout,doe,nrd,nwr,busy,done,to}=%h, want %h",
               nm, $time, act, exp);
    end
  endtask

  task automatic chk_eq(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, want %h", nm, $time, act, exp);
    end
  endtask

  task automatic drive_busy(input bit hold, input bit rd, input bit wr);
    if (hold) begin
      RD = rd;
      WR = wr;
    end else begin
      RD = 1'($urandom);
      WR = 1'($urandom);
    end
    DL_in = 8'($urandom);
  endtask

  // Called at a falling edge with the DUT idle; returns at a falling edge with it idle again
  task automatic run_txn(input bit rd, input bit wr, input bit hold, input logic [7:0] dl,
                         input logic [7:0] din, input int waits, output logic got_to);
    bit is_wr;
    bit to;
    int slen;
    is_wr = wr;
    to    = (waits > int'(MAXW));
    slen  = (to ? int'(MAXW) : waits) + 1;

    chk("idle", m_latch, 1'b0, m_wrbuf, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    RD = rd; WR = wr; DL_in = dl;
    WAIT = 1'($urandom); D_in = 8'($urandom);
    @(negedge CLK);

    if (is_wr) begin
      m_wrbuf = dl;
      chk("wset", m_latch, 1'b0, m_wrbuf, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      drive_busy(hold, rd, wr);
      WAIT = 1'($urandom);
      @(negedge CLK);
    end

    for (int j = 1; j <= slen; j++) begin
      chk(is_wr ? "wstb" : "rstb", m_latch, 1'b0, m_wrbuf, is_wr, is_wr, !is_wr,
          1'b1, 1'b0, 1'b0);
      drive_busy(hold, rd, wr);
      WAIT = (j <= waits);
      D_in = (j == slen) ? din : 8'($urandom);
      @(negedge CLK);
    end

    if (!is_wr) m_latch = to ? 8'hFF : din;
    chk(is_wr ? "whld" : "rdrv", m_latch, !is_wr, m_wrbuf, is_wr, 1'b1, 1'b1,
        1'b1, 1'b1, to);
    got_to = TIMEOUT;
    drive_busy(hold, rd, wr);
    WAIT = 1'($urandom);
    @(negedge CLK);
  endtask

  initial begin
    logic got_to;

    vecs[0] = '{1'b1, 1'b0, 8'h00, 8'h5A,  0, 8'h5A, 8'h00, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 8'hC3, 8'h00,  0, 8'h5A, 8'hC3, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 8'h00, 8'h21,  3, 8'h21, 8'hC3, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 8'h00, 8'h33, 40, 8'hFF, 8'hC3, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 8'h3C, 8'h00, 40, 8'hFF, 8'h3C, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 8'h96, 8'h77,  0, 8'hFF, 8'h96, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 8'h00, 8'h00, 15, 8'h00, 8'h96, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 8'hA5, 8'h00, 16, 8'h00, 8'hA5, 1'b1};
    vecs[8] = '{1'b1, 1'b0, 8'h00, 8'hE7, 16, 8'hFF, 8'hA5, 1'b1};

    RESET = 1'b1; RD = 1'b0; WR = 1'b0; WAIT = 1'b0; DL_in = 8'h00; D_in = 8'h00;
    repeat (3) @(negedge CLK);
    chk("reset", 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    RESET = 1'b0;
    @(negedge CLK);

    foreach (vecs[i]) begin
      run_txn(vecs[i].rd, vecs[i].wr, 1'b0, vecs[i].dl, vecs[i].din, vecs[i].waits, got_to);
      chk_eq($sformatf("vec%0d_latch", i), LATCH, vecs[i].exp_latch);
      chk_eq($sformatf("vec%0d_dout", i), D_out, vecs[i].exp_dout);
      chk_eq($sformatf("vec%0d_timeout", i), 8'(got_to), 8'(vecs[i].exp_to));
    end

    // RD held high: back-to-back reads with one idle cycle between them
    for (int i = 0; i < 3; i++)
      run_txn(1'b1, 1'b0, 1'b1, 8'h00, 8'(8'h10 + i), 0, got_to);
    // WR held high: back-to-back writes
    for (int i = 0; i < 2; i++)
      run_txn(1'b0, 1'b1, 1'b1, 8'(8'h80 + i), 8'h00, 1, got_to);
    RD = 1'b0; WR = 1'b0;
    @(negedge CLK);
    chk("hold_idle", m_latch, 1'b0, m_wrbuf, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset asserted in the middle of a stalled write strobe
    WR = 1'b1; DL_in = 8'h4B; WAIT = 1'b1;
    @(negedge CLK);
    WR = 1'b0; RD = 1'b1;
    chk("rst_wset", m_latch, 1'b0, 8'h4B, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge CLK);
    chk("rst_wstb", m_latch, 1'b0, 8'h4B, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    RESET = 1'b1; RD = 1'b0;
    @(negedge CLK);
    chk("rst_mid", 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    RESET = 1'b0; WAIT = 1'b0;
    m_latch = 8'h00; m_wrbuf = 8'h00;
    @(negedge CLK);
    chk("rst_after", 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Random transactions with random waits and junk on RD/WR while busy
    for (int i = 0; i < 40; i++) begin
      bit r, w;
      int wt;
      r = 1'($urandom);
      w = 1'($urandom);
      if (!r && !w) r = 1'b1;
      wt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 4));
      run_txn(r, w, 1'b0, 8'($urandom), 8'($urandom), wt, got_to);
      RD = 1'b0; WR = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        @(negedge CLK);
        chk("rand_gap", m_latch, 1'b0, m_wrbuf, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
